// File: rtl/qtz_seg_collector.sv
// Level-HV collector: gathers FEATURES_PER_CC level hypervectors per accepted
// segment into a FEATURE_COUNT-entry array and flags when the sample is complete.
module qtz_seg_collector #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURE_COUNT   = 617,
    parameter int FEATURES_PER_CC = 62,
    parameter bit CLEAR_ON_START  = 1'b0,
    localparam int NUM_SEGS = (FEATURE_COUNT + FEATURES_PER_CC - 1) / FEATURES_PER_CC,
    localparam int SEG_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              seg_valid,
    output logic              seg_ready,
    input  logic [HV_DIM-1:0] seg_data  [0:FEATURES_PER_CC-1],
    output logic [SEG_W-1:0]  seg_idx,
    output logic [HV_DIM-1:0] level_hvs [0:FEATURE_COUNT-1],
    output logic              hvs_valid,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEG_W-1:0] seg_idx_q, seg_idx_d;
    logic             done_q, done_d;

    logic accept;
    logic last_seg;
    logic start_take;
    logic clear_en;

    assign last_seg   = (seg_idx_q == SEG_W'(NUM_SEGS - 1));
    assign accept     = seg_valid && (state_q == COLLECT) && !abort;
    assign start_take = start && !abort && (state_q != COLLECT);
    assign clear_en   = CLEAR_ON_START && start_take;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            seg_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; abort overrides everything else
    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        done_d    = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            seg_idx_d = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (start) begin
                        state_d   = COLLECT;
                        seg_idx_d = '0;
                    end
                end
                COLLECT: begin
                    if (seg_valid) begin
                        if (last_seg) begin
                            state_d   = HOLD;
                            seg_idx_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            seg_idx_d = seg_idx_q + SEG_W'(1);
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    seg_idx_d = '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        seg_ready = (state_q == COLLECT) && !abort;
        busy      = (state_q == COLLECT);
        hvs_valid = (state_q == HOLD);
        done      = done_q;
        seg_idx   = seg_idx_q;
    end

    // Each entry is statically bound to one (segment, lane) pair, so unused
    // lanes of a short last segment simply have no entry to land in.
    for (genvar gi = 0; gi < FEATURE_COUNT; gi++) begin : g_entry
        localparam int SEG  = gi / FEATURES_PER_CC;
        localparam int LANE = gi % FEATURES_PER_CC;

        logic [HV_DIM-1:0] entry_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_q <= '0;
            end else if (clear_en) begin
                entry_q <= '0;
            end else if (accept && (seg_idx_q == SEG_W'(SEG))) begin
                entry_q <= seg_data[LANE];
            end
        end

        assign level_hvs[gi] = entry_q;
    end

endmodule
